// File: rtl/mem_access_stage_pkg.sv
// Control-bus bit positions shared by the EX, MEM and WB stages.
package mem_access_stage_pkg;
  localparam int MEM_BRANCH    = 0;
  localparam int MEM_READ      = 1;
  localparam int MEM_WRITE     = 2;
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;
endpackage

// File: rtl/data_memory.sv
// Single-port data RAM: synchronous write, registered read (1 cycle, read-before-write),
// asynchronous debug read. enable=0 freezes both the read register and writes.
module data_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [MEM_ADDR_BITS-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  input  logic [MEM_ADDR_BITS-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0]    debug_data
);
  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array has no reset; writes are gated off while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && enable && mem_write) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (enable) begin
      rdata <= mem_read ? mem[addr] : '0;
    end
  end

  assign debug_data = mem[debug_addr];
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data access, branch resolve, MEM forwarding and MEM/WB register.
// Registered outputs have 1-cycle latency; enable=0 holds them and blocks stores.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_BITS     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_ADDR_BITS = 8,
  parameter int MEM_BUS_WIDTH = 3,
  parameter int WB_BUS_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [MEM_BUS_WIDTH-1:0] memory_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]  wb_bus_in,
  input  logic [DATA_WIDTH-1:0]    alu_result_in,
  input  logic [DATA_WIDTH-1:0]    reg_rt_data_in,
  input  logic [REG_ADDR_BITS-1:0] add_reg_w_in,
  input  logic [ADDR_BITS-1:0]     next_pc_in,
  input  logic                     alu_zero_flag_in,
  input  logic [MEM_ADDR_BITS-1:0] debug_addr_in,
  output logic                     pc_src_out,
  output logic [ADDR_BITS-1:0]     branch_target_out,
  output logic [DATA_WIDTH-1:0]    fw_mem_data_out,
  output logic [REG_ADDR_BITS-1:0] fw_mem_reg_out,
  output logic                     fw_mem_reg_write_out,
  output logic [DATA_WIDTH-1:0]    read_data_out,
  output logic [DATA_WIDTH-1:0]    alu_result_out,
  output logic [REG_ADDR_BITS-1:0] add_reg_w_out,
  output logic [WB_BUS_WIDTH-1:0]  wb_bus_out,
  output logic [DATA_WIDTH-1:0]    debug_data_out
);
  assign pc_src_out           = memory_bus_in[MEM_BRANCH] & alu_zero_flag_in;
  assign branch_target_out    = next_pc_in;
  assign fw_mem_data_out      = alu_result_in;
  assign fw_mem_reg_out       = add_reg_w_in;
  assign fw_mem_reg_write_out = wb_bus_in[WB_REG_WRITE];

  // Byte address -> word index; upper bits dropped so accesses wrap.
  data_memory #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) u_data_memory (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mem_read  (memory_bus_in[MEM_READ]),
    .mem_write (memory_bus_in[MEM_WRITE]),
    .addr      (alu_result_in[MEM_ADDR_BITS+1:2]),
    .wdata     (reg_rt_data_in),
    .rdata     (read_data_out),
    .debug_addr(debug_addr_in),
    .debug_data(debug_data_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out <= '0;
      add_reg_w_out  <= '0;
      wb_bus_out     <= '0;
    end else if (enable) begin
      alu_result_out <= alu_result_in;
      add_reg_w_out  <= add_reg_w_in;
      wb_bus_out     <= wb_bus_in;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic against a word-array model.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  memory_bus_in;
  logic [1:0]  wb_bus_in;
  logic [31:0] alu_result_in;
  logic [31:0] reg_rt_data_in;
  logic [4:0]  add_reg_w_in;
  logic [31:0] next_pc_in;
  logic        alu_zero_flag_in;
  logic [7:0]  debug_addr_in;
  logic        pc_src_out;
  logic [31:0] branch_target_out;
  logic [31:0] fw_mem_data_out;
  logic [4:0]  fw_mem_reg_out;
  logic        fw_mem_reg_write_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  add_reg_w_out;
  logic [1:0]  wb_bus_out;
  logic [31:0] debug_data_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [256];
  logic [31:0] m_rd, m_alu;
  logic [4:0]  m_reg;
  logic [1:0]  m_wb;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .memory_bus_in(memory_bus_in),
    .wb_bus_in(wb_bus_in), .alu_result_in(alu_result_in), .reg_rt_data_in(reg_rt_data_in),
    .add_reg_w_in(add_reg_w_in), .next_pc_in(next_pc_in), .alu_zero_flag_in(alu_zero_flag_in),
    .debug_addr_in(debug_addr_in), .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
    .fw_mem_data_out(fw_mem_data_out), .fw_mem_reg_out(fw_mem_reg_out),
    .fw_mem_reg_write_out(fw_mem_reg_write_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .add_reg_w_out(add_reg_w_out), .wb_bus_out(wb_bus_out),
    .debug_data_out(debug_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    check("read_data", read_data_out, m_rd);
    check("alu_result", alu_result_out, m_alu);
    check("add_reg_w", {27'd0, add_reg_w_out}, {27'd0, m_reg});
    check("wb_bus", {30'd0, wb_bus_out}, {30'd0, m_wb});
    check("debug_data", debug_data_out, mem_m[debug_addr_in]);
  endtask

  // One pipeline cycle: apply inputs, check combinational outputs, clock, check registers.
  task automatic cycle(input logic en, input logic [2:0] mb, input logic [1:0] wb,
                       input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                       input logic [31:0] npc, input logic z, input logic [7:0] dbg);
    int idx;
    enable = en; memory_bus_in = mb; wb_bus_in = wb; alu_result_in = alu;
    reg_rt_data_in = rt; add_reg_w_in = rd; next_pc_in = npc;
    alu_zero_flag_in = z; debug_addr_in = dbg;
    #1;
    check("pc_src", {31'd0, pc_src_out}, {31'd0, mb[0] && z});
    check("branch_target", branch_target_out, npc);
    check("fw_data", fw_mem_data_out, alu);
    check("fw_reg", {27'd0, fw_mem_reg_out}, {27'd0, rd});
    check("fw_reg_write", {31'd0, fw_mem_reg_write_out}, {31'd0, wb[0]});
    check("debug_pre", debug_data_out, mem_m[dbg]);
    @(posedge clk);
    idx = int'(alu / 4) % 256;
    if (en) begin
      m_rd = mb[1] ? mem_m[idx] : 32'd0;
      if (mb[2]) mem_m[idx] = rt;
      m_alu = alu; m_reg = rd; m_wb = wb;
    end
    #1;
    check_regs();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; memory_bus_in = '0; wb_bus_in = '0;
    alu_result_in = '0; reg_rt_data_in = '0; add_reg_w_in = '0; next_pc_in = '0;
    alu_zero_flag_in = 1'b0; debug_addr_in = '0;
    m_rd = '0; m_alu = '0; m_reg = '0; m_wb = '0;
    #12;
    check("reset_rd", read_data_out, 32'd0);
    check("reset_alu", alu_result_out, 32'd0);
    check("reset_reg", {27'd0, add_reg_w_out}, 32'd0);
    check("reset_wb", {30'd0, wb_bus_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < 256; i++)
      cycle(1'b1, 3'b100, 2'b00, i * 4, $urandom, 5'd0, 32'd0, 1'b0, 8'(i));

    // Store then load at 0x10.
    cycle(1'b1, 3'b100, 2'b00, 32'h10, 32'hDEADBEEF, 5'd1, 32'd0, 1'b0, 8'd4);
    cycle(1'b1, 3'b010, 2'b11, 32'h10, 32'h0, 5'd2, 32'd0, 1'b0, 8'd4);
    check("store_load", read_data_out, 32'hDEADBEEF);

    // Address wrap: 0x410 and 0x010 hit word 4.
    cycle(1'b1, 3'b100, 2'b00, 32'h410, 32'h1234, 5'd0, 32'd0, 1'b0, 8'd4);
    check("wrap_debug", debug_data_out, 32'h1234);
    cycle(1'b1, 3'b010, 2'b00, 32'h010, 32'h0, 5'd0, 32'd0, 1'b0, 8'd4);
    check("wrap_load", read_data_out, 32'h1234);

    // Branch resolution.
    cycle(1'b1, 3'b001, 2'b00, 32'h0, 32'h0, 5'd0, 32'h40, 1'b1, 8'd0);
    enable = 1'b0; memory_bus_in = 3'b001; alu_zero_flag_in = 1'b1; next_pc_in = 32'h40; #1;
    check("branch_taken", {31'd0, pc_src_out}, 32'd1);
    check("branch_target_40", branch_target_out, 32'h40);
    alu_zero_flag_in = 1'b0; #1;
    check("branch_not_taken", {31'd0, pc_src_out}, 32'd0);

    // Read-and-write together returns the old word.
    cycle(1'b1, 3'b110, 2'b01, 32'h20, 32'hCAFEF00D, 5'd3, 32'd0, 1'b0, 8'd8);
    check("rbw_new", debug_data_out, 32'hCAFEF00D);

    // Stall blocks the store and holds registers, then enable lets it through.
    cycle(1'b1, 3'b000, 2'b11, 32'h77, 32'h0, 5'd9, 32'd0, 1'b0, 8'd7);
    check("pass_alu", alu_result_out, 32'h77);
    check("pass_reg", {27'd0, add_reg_w_out}, 32'd9);
    check("pass_wb", {30'd0, wb_bus_out}, 32'd3);
    check("no_access_rd", read_data_out, 32'd0);
    cycle(1'b0, 3'b100, 2'b00, 32'h1C, 32'h55, 5'd4, 32'd0, 1'b0, 8'd7);
    check("stall_alu_hold", alu_result_out, 32'h77);
    cycle(1'b1, 3'b100, 2'b00, 32'h1C, 32'h55, 5'd4, 32'd0, 1'b0, 8'd7);
    check("stall_release", debug_data_out, 32'h55);

    // Asynchronous reset mid-cycle; stores are blocked while held.
    cycle(1'b1, 3'b010, 2'b10, 32'h1C, 32'h0, 5'd6, 32'd0, 1'b0, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    m_rd = '0; m_alu = '0; m_reg = '0; m_wb = '0;
    check_regs();
    enable = 1'b1; memory_bus_in = 3'b100; alu_result_in = 32'hC; reg_rt_data_in = 32'hBAD0BAD0;
    debug_addr_in = 8'd3;
    @(posedge clk); #1;
    check("reset_no_write", debug_data_out, mem_m[3]);
    check_regs();
    #2 rst_n = 1'b1;
    #1;

    // Random traffic over a small index window to exercise back-to-back hazards.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      cycle($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            a, $urandom, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It is the receiving end of the EX/MEM interface driven by the execute stage.
- Consumes the registered ALU result, store data, destination register, next PC, zero flag, memory control bus and WB control bus.
- Performs data-memory access, resolves the branch decision, and provides the MEM-stage forwarding source.
- Drives the MEM/WB pipeline register toward the writeback stage.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ADDR_BITS, 32, PC / branch target width.
- REG_ADDR_BITS, 5, register-file address width.
- MEM_ADDR_BITS, 8, log2 of data-memory depth in words (256 words).
- MEM_BUS_WIDTH, 3, memory control bus width.
- WB_BUS_WIDTH, 2, writeback control bus width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  pipeline advance; low = stage frozen (debug step/stall).
- memory_bus_in  in  MEM_BUS_WIDTH  bit0 branch, bit1 mem_read, bit2 mem_write.
- wb_bus_in  in  WB_BUS_WIDTH  bit0 reg_write, bit1 mem_to_reg; passed through.
- alu_result_in  in  DATA_WIDTH  ALU result; byte address for loads/stores.
- reg_rt_data_in  in  DATA_WIDTH  store data.
- add_reg_w_in  in  REG_ADDR_BITS  destination register.
- next_pc_in  in  ADDR_BITS  branch target.
- alu_zero_flag_in  in  1  ALU zero flag.
- debug_addr_in  in  MEM_ADDR_BITS  debug word index.
- pc_src_out  out  1  branch taken (combinational).
- branch_target_out  out  ADDR_BITS  equals next_pc_in (combinational).
- fw_mem_data_out  out  DATA_WIDTH  equals alu_result_in; MEM forwarding source.
- fw_mem_reg_out  out  REG_ADDR_BITS  equals add_reg_w_in.
- fw_mem_reg_write_out  out  1  equals wb_bus_in[0].
- read_data_out  out  DATA_WIDTH  registered load data.
- alu_result_out  out  DATA_WIDTH  registered ALU result.
- add_reg_w_out  out  REG_ADDR_BITS  registered destination register.
- wb_bus_out  out  WB_BUS_WIDTH  registered WB control.
- debug_data_out  out  DATA_WIDTH  combinational read of mem[debug_addr_in].

Behaviour:
- Reset (rst_n low, asynchronous) clears all registered outputs to 0. Memory contents are not reset. Reset asserted mid-operation forces the outputs to 0 immediately, and no write occurs while rst_n is low.
- Word index = alu_result_in[MEM_ADDR_BITS+1:2]. Bits [1:0] and all bits above the index are ignored, so addresses wrap modulo depth.
- Store: on a rising edge with enable=1 and mem_write=1, mem[index] <= reg_rt_data_in.
- Load: with mem_read=1, read_data_out <= mem[index] at the same edge. Latency is 1 cycle, aligned with alu_result_out.
- If neither mem_read nor mem_write is set, read_data_out <= 0.
- If mem_read and mem_write are both set: the write happens, and read_data_out returns the old word (read-before-write).
- MEM/WB register: alu_result_out, add_reg_w_out, wb_bus_out and read_data_out update on every rising edge with enable=1. With enable=0 they hold.
- enable=0 suppresses memory writes.
- pc_src_out = branch & alu_zero_flag_in, regardless of enable.
- A store followed next cycle by a load to the same index returns the new data.
- No state machine. The block is a pipeline register plus a synchronous-write, synchronous-read RAM. Debug read is asynchronous and independent of enable.

Decomposition:
- Shared package holds the memory-bus bit indices (MEM_BRANCH=0, MEM_READ=1, MEM_WRITE=2) and WB bit indices (WB_REG_WRITE=0, WB_MEM_TO_REG=1). The execute stage and the WB stage reuse them.
- One sub-module: data_memory, a single-port RAM with synchronous write, registered read and an asynchronous debug read port.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> all registered outputs become 0 immediately, without a clock edge.
- Store/load: store with alu_result_in=0x10 and reg_rt_data_in=0xDEADBEEF, then load with alu_result_in=0x10 on the next cycle -> read_data_out=0xDEADBEEF one cycle after the load.
- Wrap: store 0x1234 at address 0x410 (index 4), then load address 0x010 -> 0x1234. debug_addr_in=4 also gives debug_data_out=0x1234.
- Branch: branch=1 with zero=1 and next_pc_in=0x40 -> pc_src_out=1 and branch_target_out=0x40. With zero=0 -> pc_src_out=0.
- Stall: enable=0 with a store of 0x55 to index 7 -> mem[7] is unchanged and the outputs hold previous values. After enable=1 the store takes effect.
- Passthrough: wb_bus_in=2'b11, add_reg_w_in=5'd9, alu_result_in=0x77 -> the same values appear on the outputs after 1 cycle. The fw_* outputs reflect the inputs in the same cycle.
